ber_checker: RTL and testbench
==============================

Name: ber_checker

Overview:
- Receive-side end of the noise channel: takes the saturated noisy samples produced by the noise adder and slices each one to a hard bit decision.
- Compares each decision against the transmitted reference bit, which is held in a small alignment FIFO.
- Accumulates bit and error counts until a programmed target is reached.
- Counts are read by software to compute BER for each noise probability table.

Parameters:
- SIGNAL_RESOLUTION, 8, width of the signed rx sample.
- FIFO_DEPTH, 16, reference alignment FIFO depth; power of two, at least 2.
- CNT_WIDTH, 64, width of the bit and error counters and of target_bits.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse: clear counters and FIFO, begin a run
- abort  in  1  single-cycle pulse: stop the run, hold counters
- target_bits  in  CNT_WIDTH  bits to compare per run; 0 = run until abort
- ref_bit_in  in  1  transmitted bit (1 = positive amplitude)
- ref_valid  in  1  ref_bit_in qualifier
- rx_in  in  SIGNAL_RESOLUTION  signed noisy sample
- rx_valid  in  1  rx_in qualifier
- bit_count  out  CNT_WIDTH  compared bits this run
- error_count  out  CNT_WIDTH  mismatches this run
- busy  out  1  high in RUN
- done  out  1  high in DONE
- overflow  out  1  sticky: reference push dropped because the FIFO was full
- underflow  out  1  sticky: rx sample arrived with the FIFO empty

Behaviour:
- Reset (rstn low, asynchronous):
  - State IDLE; FIFO empty; pointers 0.
  - All outputs 0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start -> RUN. In the same edge, clear counters, FIFO pointers, overflow and underflow.
  - Counters hold.
- RUN:
  - Push: ref_valid pushes ref_bit_in.
  - Pop: rx_valid with FIFO non-empty pops one entry.
  - Slicer: decision = ~rx_in[MSB]. A sample of 0 decides 1.
  - On each pop:
    - bit_count increments by 1.
    - error_count increments by 1 when decision != popped bit.
    - Both counters are registered and visible 1 cycle after the rx_valid edge.
  - If target_bits != 0 and the incremented bit_count == target_bits -> DONE in the same edge. Further rx in DONE is ignored.
  - abort -> IDLE, counters hold.
  - If start and abort are both asserted, start wins: re-clear, stay in RUN.
  - start while in RUN re-clears and stays in RUN.
- DONE:
  - Counters hold; done = 1.
  - start -> RUN with clear; abort -> IDLE.
- FIFO boundary rules:
  - Simultaneous push and pop when full: both take effect, and the count is unchanged.
  - Push when full and no pop: bit dropped, overflow set.
  - rx_valid when FIFO empty:
    - The sample is discarded and not counted; underflow is set.
    - There is no bypass, even if a push occurs in the same cycle. That push is still written.
  - Pointers wrap modulo FIFO_DEPTH. A separate count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.
  - Outside RUN, ref_valid and rx_valid are ignored and the FIFO is unchanged.
- Counters saturate at all-ones and never wrap.
- target_bits is sampled continuously. Lowering it below bit_count mid-run never terminates the run; only equality does.
- Sticky flags clear only on start or reset.

Decomposition:
- Package ber_pkg:
  - state enum {IDLE, RUN, DONE}.
  - slice function (sign to bit).
  - sat_inc function (saturating counter increment).
- One sub-module, ber_ref_fifo:
  - Parameterised by depth.
  - Ports: push, pop, din, dout, full, empty, sync clear.
  - Same clk and rstn.
- Top level: FSM, slicer and counters.

Test Plan:
- Clean channel: start, target_bits=8; push 8 reference bits 10110010 and feed rx samples of +40 or -40 matching each bit -> bit_count=8, error_count=0, done=1 one cycle after the 8th rx, busy=0.
- Errors: same as the clean-channel scenario, but rx samples 2 and 5 are sign-flipped (the sample 0 counts as +) -> error_count=2 at done. Repeat with rx_in=0 against reference 0 -> that bit counts as an error.
- FIFO full: push 17 reference bits with no rx (FIFO_DEPTH=16) -> overflow=1 and 16 bits stored. Then a push and pop in the same cycle at full -> the FIFO stays at 16 and overflow is not newly triggered.
- Underflow: in RUN with the FIFO empty, rx_valid=1 together with ref_valid=1 -> underflow=1, bit_count stays 0, the FIFO holds 1 entry.
- Free-run, abort and saturation:
  - target_bits=0 with 100 matched bits, then abort -> IDLE, bit_count=100 held, done=0.
  - Next start -> counters 0.
  - Force CNT_WIDTH=4 and run 20 bits -> bit_count holds at 15.
- Asynchronous reset mid-run: deassert rstn between clock edges after 5 bits -> outputs 0 immediately, FIFO empty, IDLE. After rstn releases, rx_valid is ignored until start.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared types and helpers for the BER checker: FSM state encoding,
// hard-decision slicer and saturating counter increment.
package ber_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Widest counter/sample the helpers handle; callers size-cast in and out.
  localparam int SAT_MAX_W = 128;

  // Sign test on the sign-extended sample: non-negative (including 0) decides 1.
  function automatic logic slice(input logic signed [SAT_MAX_W-1:0] sample);
    return sample >= 0;
  endfunction

  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] val,
                                                   input logic [SAT_MAX_W-1:0] max_val);
    return (val == max_val) ? val : val + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/ber_ref_fifo.sv
// Reference-bit alignment FIFO: 1-bit wide, power-of-two depth, synchronous clear.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module ber_ref_fifo #(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count/pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ber_checker.sv
// Receive-side bit error rate checker: slices noisy samples, compares them with
// FIFO-aligned reference bits and counts bits/errors until a programmed target.
module ber_checker
  import ber_pkg::*;
#(
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int FIFO_DEPTH        = 16,
  parameter int CNT_WIDTH         = 64
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                start,
  input  logic                                abort,
  input  logic [CNT_WIDTH-1:0]                target_bits,
  input  logic                                ref_bit_in,
  input  logic                                ref_valid,
  input  logic signed [SIGNAL_RESOLUTION-1:0] rx_in,
  input  logic                                rx_valid,
  output logic [CNT_WIDTH-1:0]                bit_count,
  output logic [CNT_WIDTH-1:0]                error_count,
  output logic                                busy,
  output logic                                done,
  output logic                                overflow,
  output logic                                underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e               state;
  logic                 active;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 decision;
  logic [CNT_WIDTH-1:0] bit_next;
  logic [CNT_WIDTH-1:0] err_next;

  // start and abort both take priority over data movement in the cycle they arrive.
  assign active    = (state == ST_RUN) & ~start & ~abort;
  assign fifo_push = active & ref_valid;
  assign fifo_pop  = active & rx_valid & ~fifo_empty;

  assign decision = slice(SAT_MAX_W'(rx_in));
  assign bit_next = CNT_WIDTH'(sat_inc(SAT_MAX_W'(bit_count), SAT_MAX_W'(CNT_MAX)));
  assign err_next = CNT_WIDTH'(sat_inc(SAT_MAX_W'(error_count), SAT_MAX_W'(CNT_MAX)));

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  ber_ref_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_ref_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (ref_bit_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      bit_count   <= '0;
      error_count <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (start) begin
      state       <= ST_RUN;
      bit_count   <= '0;
      error_count <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            if (rx_valid && fifo_empty)               underflow <= 1'b1;
            if (ref_valid && fifo_full && !fifo_pop) overflow  <= 1'b1;
            if (fifo_pop) begin
              bit_count <= bit_next;
              if (decision != fifo_dout) error_count <= err_next;
              // Only exact equality ends a run; a target lowered below the count never does.
              if (target_bits != '0 && bit_next == target_bits) state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (abort) state <= ST_IDLE;
        end
        ST_IDLE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ber_checker.sv
// Self-checking bench for ber_checker: directed scenarios plus a randomized phase,
// checked against a queue-based model of the channel checker.
module tb_ber_checker;

  localparam int DEPTH = 16;

  logic               clk;
  logic               rstn;
  logic               start;
  logic               abort;
  logic [63:0]        target_bits;
  logic               ref_bit_in;
  logic               ref_valid;
  logic signed [7:0]  rx_in;
  logic               rx_valid;
  logic [63:0]        bit_count;
  logic [63:0]        error_count;
  logic               busy;
  logic               done;
  logic               overflow;
  logic               underflow;
  logic [3:0]         bit_count4;
  logic [3:0]         error_count4;
  logic               busy4;
  logic               done4;
  logic               overflow4;
  logic               underflow4;

  int tests = 0;
  int fails = 0;

  typedef enum {M_IDLE, M_RUN, M_DONE} mstate_e;
  mstate_e         m_state;
  bit              m_q[$];
  longint unsigned m_bits;
  longint unsigned m_errs;
  bit              m_ovf;
  bit              m_unf;

  ber_checker #(.SIGNAL_RESOLUTION(8), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(64)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .target_bits(target_bits),
    .ref_bit_in(ref_bit_in), .ref_valid(ref_valid), .rx_in(rx_in), .rx_valid(rx_valid),
    .bit_count(bit_count), .error_count(error_count), .busy(busy), .done(done),
    .overflow(overflow), .underflow(underflow)
  );

  ber_checker #(.SIGNAL_RESOLUTION(8), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .target_bits(4'd0),
    .ref_bit_in(ref_bit_in), .ref_valid(ref_valid), .rx_in(rx_in), .rx_valid(rx_valid),
    .bit_count(bit_count4), .error_count(error_count4), .busy(busy4), .done(done4),
    .overflow(overflow4), .underflow(underflow4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [7:0] amp(input bit b);
    return b ? 8'sd40 : -8'sd40;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_q.delete();
    m_bits = 0;
    m_errs = 0;
    m_ovf  = 0;
    m_unf  = 0;
  endtask

  // One clock edge of the channel checker as described at the behavioural level.
  task automatic model_update(input bit st, input bit ab, input bit rv, input bit rb,
                              input bit xv, input logic signed [7:0] xs);
    bit popped;
    bit decided;
    bit had_entry;
    if (st) begin
      model_reset();
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (ab) begin
        m_state = M_IDLE;
      end else begin
        had_entry = (m_q.size() > 0);
        if (xv && !had_entry) m_unf = 1;
        if (xv && had_entry) begin
          popped  = m_q.pop_front();
          decided = (xs >= 0);
          m_bits++;
          if (decided != popped) m_errs++;
          if (target_bits != 0 && m_bits == target_bits) m_state = M_DONE;
        end
        if (rv) begin
          if (m_q.size() < DEPTH) m_q.push_back(rb);
          else m_ovf = 1;
        end
      end
    end else if (m_state == M_DONE && ab) begin
      m_state = M_IDLE;
    end
  endtask

  task automatic compare(input string tag);
    check({tag, ".bit_count"},   bit_count,       m_bits);
    check({tag, ".error_count"}, error_count,     m_errs);
    check({tag, ".busy"},        64'(busy),       64'(m_state == M_RUN));
    check({tag, ".done"},        64'(done),       64'(m_state == M_DONE));
    check({tag, ".overflow"},    64'(overflow),   64'(m_ovf));
    check({tag, ".underflow"},   64'(underflow),  64'(m_unf));
  endtask

  // Called at posedge+1; drives, takes one edge, advances the model, compares.
  task automatic step(input bit st, input bit ab, input bit rv, input bit rb,
                      input bit xv, input logic signed [7:0] xs, input string tag);
    start      = st;
    abort      = ab;
    ref_valid  = rv;
    ref_bit_in = rb;
    rx_valid   = xv;
    rx_in      = xs;
    @(posedge clk);
    model_update(st, ab, rv, rb, xv, xs);
    #1;
    start     = 1'b0;
    abort     = 1'b0;
    ref_valid = 1'b0;
    rx_valid  = 1'b0;
    compare(tag);
  endtask

  initial begin
    bit [7:0] pat;
    bit       pb[18];
    bit       prev;
    bit       nb;

    rstn = 1'b0; start = 1'b0; abort = 1'b0; target_bits = '0;
    ref_bit_in = 1'b0; ref_valid = 1'b0; rx_in = '0; rx_valid = 1'b0;
    model_reset();
    #12;
    compare("reset");
    check("reset.bit_count4", 64'(bit_count4), 64'd0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Clean channel, pattern 10110010 sent MSB first.
    pat = 8'b1011_0010;
    target_bits = 64'd8;
    step(1, 0, 0, 0, 0, 0, "clean.start");
    for (int i = 0; i < 8; i++) step(0, 0, 1, pat[7-i], 0, 0, "clean.push");
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, amp(pat[7-i]), "clean.rx");
    check("clean.final_bits", bit_count, 64'd8);
    check("clean.final_errs", error_count, 64'd0);
    check("clean.final_done", 64'(done), 64'd1);
    check("clean.final_busy", 64'(busy), 64'd0);
    step(0, 0, 0, 0, 1, amp(1'b0), "done.rx_ignored");

    // Samples 2 and 5 sign-flipped.
    step(1, 0, 0, 0, 0, 0, "err.start");
    for (int i = 0; i < 8; i++) step(0, 0, 1, pat[7-i], 0, 0, "err.push");
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 0, 1, (i == 1 || i == 4) ? amp(~pat[7-i]) : amp(pat[7-i]), "err.rx");
    check("err.final_errs", error_count, 64'd2);
    check("err.final_done", 64'(done), 64'd1);

    // A zero sample decides 1, so against reference 0 it is an error.
    target_bits = 64'd1;
    step(1, 0, 0, 0, 0, 0, "zero.start");
    step(0, 0, 1, 1'b0, 0, 0, "zero.push");
    step(0, 0, 0, 0, 1, 8'sd0, "zero.rx");
    check("zero.errs", error_count, 64'd1);
    step(0, 1, 0, 0, 0, 0, "zero.abort_in_done");
    check("zero.held_bits", bit_count, 64'd1);

    // FIFO full: 16 pushes, push+pop at full, then a dropped push.
    target_bits = 64'd0;
    step(1, 0, 0, 0, 0, 0, "full.start");
    foreach (pb[i]) pb[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 16; i++) step(0, 0, 1, pb[i], 0, 0, "full.push");
    check("full.no_ovf_at_16", 64'(overflow), 64'd0);
    step(0, 0, 1, pb[16], 1, amp(pb[0]), "full.push_pop");
    check("full.push_pop_no_ovf", 64'(overflow), 64'd0);
    step(0, 0, 1, pb[17], 0, 0, "full.drop");
    check("full.ovf_set", 64'(overflow), 64'd1);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 1, amp(pb[i+1]), "full.drain");
    check("full.drain_errs", error_count, 64'd0);
    check("full.drain_bits", bit_count, 64'd17);
    check("full.no_unf", 64'(underflow), 64'd0);
    step(0, 0, 0, 0, 1, amp(1'b1), "full.extra_rx");
    check("full.unf_set", 64'(underflow), 64'd1);

    // Underflow with a simultaneous push: no bypass, push still lands.
    step(1, 0, 0, 0, 0, 0, "unf.start");
    step(0, 0, 1, 1'b1, 1, amp(1'b0), "unf.push_rx");
    check("unf.flag", 64'(underflow), 64'd1);
    check("unf.bits", bit_count, 64'd0);
    step(0, 0, 0, 0, 1, amp(1'b1), "unf.pop_stored");
    check("unf.stored_pop", bit_count, 64'd1);

    // Free run of 100 bits, then abort and restart.
    step(1, 0, 0, 0, 0, 0, "free.start");
    prev = 1'($urandom_range(0, 1));
    step(0, 0, 1, prev, 0, 0, "free.prime");
    for (int i = 0; i < 100; i++) begin
      nb = 1'($urandom_range(0, 1));
      step(0, 0, 1, nb, 1, 8'($urandom_range(0, 255)), "free.run");
    end
    check("free.bits100", bit_count, 64'd100);
    step(0, 1, 0, 0, 0, 0, "free.abort");
    check("free.abort_bits", bit_count, 64'd100);
    check("free.abort_busy", 64'(busy), 64'd0);
    check("free.abort_done", 64'(done), 64'd0);
    step(1, 0, 0, 0, 0, 0, "free.restart");
    check("free.restart_bits", bit_count, 64'd0);

    // Saturation on the 4-bit instance with a matched channel.
    prev = 1'($urandom_range(0, 1));
    step(0, 0, 1, prev, 0, 0, "sat.prime");
    for (int i = 0; i < 20; i++) begin
      nb = 1'($urandom_range(0, 1));
      step(0, 0, 1, nb, 1, amp(prev), "sat.run");
      prev = nb;
    end
    check("sat.bits4", 64'(bit_count4), 64'd15);
    check("sat.errs4", 64'(error_count4), 64'd0);
    check("sat.busy4", 64'(busy4), 64'd1);
    check("sat.done4", 64'(done4), 64'd0);
    check("sat.flags4", 64'({overflow4, underflow4}), 64'd0);
    check("sat.bits64", bit_count, 64'd20);

    // Randomized traffic with a short target and occasional start/abort.
    target_bits = 64'($urandom_range(5, 40));
    step(1, 0, 0, 0, 0, 0, "rand.start");
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 5), 8'($urandom_range(0, 255)), "rand");
      if (done && $urandom_range(0, 3) == 0) begin
        target_bits = 64'($urandom_range(1, 40));
        step(1, 0, 0, 0, 0, 0, "rand.restart");
      end
    end

    // Asynchronous reset between edges after 5 bits.
    target_bits = 64'd0;
    step(1, 0, 0, 0, 0, 0, "arst.start");
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1'b1, 0, 0, "arst.push");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, amp(1'b1), "arst.rx");
    #2 rstn = 1'b0;
    #1;
    model_reset();
    compare("arst.immediate");
    check("arst.bits4", 64'(bit_count4), 64'd0);
    @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1'b1, 1, amp(1'b1), "arst.idle_ignored");
    check("arst.idle_bits", bit_count, 64'd0);
    step(1, 0, 0, 0, 0, 0, "arst.restart");
    step(0, 0, 0, 0, 1, amp(1'b1), "arst.fifo_empty");
    check("arst.fifo_was_empty", 64'(underflow), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
